// File: rtl/uart_tx_flow_if.sv
// Producer-side valid/ready byte handshake into the UART transmitter FIFO.
interface uart_tx_flow_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_flow.sv
// UART transmitter with byte FIFO and clear-to-send gating; frames are start, LSB-first data,
// optional parity and stop bits, sent back-to-back while the FIFO is non-empty and cts is high.
module uart_tx_flow #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    uart_tx_flow_if.slave               prod_if,
    input  logic                        i_cts,
    output logic                        o_txd,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLK_DIV * STOP_BITS);

    localparam logic [BW-1:0] BAUD_BIT  = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_STOP = BW'(CLK_DIV * STOP_BITS - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_cts_meta;
    logic          r_cts_s;
    logic [2:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          r_txd;
    logic          r_busy;

    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;

    assign prod_if.tx_ready = (r_count != FULL_CNT);
    assign w_push           = prod_if.tx_valid && prod_if.tx_ready;
    assign w_head           = r_mem[r_rptr] & DATA_MASK;

    // A frame may only begin from IDLE or on the final cycle of STOP.
    assign w_pop = (r_count != '0) && r_cts_s &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && (r_baud == '0)));

    assign o_txd        = r_txd;
    assign o_busy       = r_busy;
    assign o_fifo_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= prod_if.tx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_cts_meta <= 1'b0;
            r_cts_s    <= 1'b0;
        end else begin
            r_cts_meta <= i_cts;
            r_cts_s    <= r_cts_meta;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    if (r_baud == '0) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                        r_baud    <= BAUD_BIT;
                        r_txd     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_baud == '0) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                r_state <= ST_PARITY;
                                r_baud  <= BAUD_BIT;
                                r_txd   <= r_parity;
                            end else begin
                                r_state <= ST_STOP;
                                r_baud  <= BAUD_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_baud    <= BAUD_BIT;
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (r_baud == '0) begin
                        r_state <= ST_STOP;
                        r_baud  <= BAUD_STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_baud == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_txd   <= 1'b1;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_txd   <= 1'b1;
                end
            endcase
            // Frame start overrides the IDLE/STOP outcome above, giving gapless frames.
            if (w_pop) begin
                r_state  <= ST_START;
                r_baud   <= BAUD_BIT;
                r_shift  <= w_head;
                r_parity <= (^w_head) ^ 1'(PARITY_ODD);
                r_txd    <= 1'b0;
                r_busy   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_tx_flow.md
Name: uart_tx_flow

Overview:
- Bench- and FPGA-side UART transmitter that drives the chip's `rxd` line, completing the UART link from the other end of the chip's receiver.
- Honours the chip's `cts`-style clear-to-send level.
- Buffers bytes from a valid/ready producer in an internal FIFO and serialises them LSB-first: start bit, data, optional parity, stop bits.
- Used by the top-level testbench in place of tying `rxd` high, and reusable as a host-side stimulus engine on FPGA.

Parameters:
- CLK_DIV, 868, clock cycles per bit (100 MHz / 115200); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal values 5..8.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 16, byte FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  synchronous, active-low reset.
- tx_data  in  8  byte to send; bits above DATA_BITS-1 are ignored.
- tx_valid  in  1  producer presents `tx_data`.
- tx_ready  out  1  FIFO not full; byte accepted when `tx_valid && tx_ready`.
- cts  in  1  clear-to-send, active-high, asynchronous to `clk`.
- txd  out  1  serial output, idles high.
- busy  out  1  high while a frame is on the line (any state except IDLE).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: `rstn` is sampled on the rising edge of `clk`. When low, the next edge forces the following:
  - state=IDLE;
  - `txd`=1, `busy`=0;
  - `fifo_count`=0, `tx_ready`=1;
  - baud counter, bit counter and shift register cleared;
  - `cts` synchroniser flops cleared to 0.
- Reset mid-frame aborts the frame: `txd` is 1 in the first cycle after the reset edge, and FIFO contents are discarded.
- `cts` passes through a 2-flop synchroniser (`cts_s`). `cts_s` is consulted only when deciding whether to start a frame.
- FIFO:
  - `tx_ready` = (`fifo_count` != FIFO_DEPTH), registered-state derived and independent of `tx_valid`.
  - Push on `tx_valid && tx_ready`; pop on frame start.
  - Push and pop in the same cycle leave `fifo_count` unchanged and are legal at any non-full occupancy.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `txd`=1. If `fifo_count`!=0 and `cts_s`=1: pop the head into the shift register, load baud counter = CLK_DIV-1, go to START.
  - START: `txd`=0 for CLK_DIV cycles, then go to DATA with bit counter = 0.
  - DATA: `txd` = shift[0]. Each bit lasts CLK_DIV cycles, then shift right. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: `txd` = XOR of the data bits, XOR PARITY_ODD; lasts CLK_DIV cycles, then go to STOP.
  - STOP: `txd`=1 for STOP_BITS*CLK_DIV cycles. On the last cycle:
    - if FIFO non-empty and `cts_s`=1, pop and go directly to START (no idle gap between frames);
    - else go to IDLE.
- `txd` and `busy` are registered outputs.
- Latency: a byte accepted at edge N into an empty FIFO while IDLE with `cts_s`=1 produces `txd`=0 starting the cycle after edge N+1.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLK_DIV cycles exactly.
- Flow control:
  - `cts` deasserting mid-frame never truncates the frame; the current frame completes.
  - No new frame starts until `cts_s`=1 (two edges after `cts` rises).
- Overflow: impossible by construction; pushes while full are not accepted and `tx_valid` is held by the producer.

Test Plan:
- CLK_DIV=4, 8N1, `cts`=1, push 0x55:
  - `txd` = 0 | 1,0,1,0,1,0,1,0 | 1, each level held 4 cycles, 40 cycles total;
  - `busy` high exactly 40 cycles;
  - `fifo_count` back to 0 one cycle after the push.
- PARITY_EN=1, push 0xA5:
  - with PARITY_ODD=0, parity bit = 0;
  - with PARITY_ODD=1, parity bit = 1;
  - frame = 44 cycles at CLK_DIV=4.
- `cts`=0, push 16 bytes 0x00..0x0F:
  - `tx_ready` drops after the 16th accept, `fifo_count`=16, `txd` stays 1;
  - raise `cts`: first start bit begins 3 cycles later;
  - frames are back-to-back with no idle gap; bytes are sent in order 0x00..0x0F.
- Drop `cts` during the DATA bit 3 of the first of two queued bytes: first frame completes intact, second is held in the FIFO; raise `cts` and the second frame starts 3 cycles later.
- Assert `rstn`=0 for 1 cycle mid-DATA with 5 bytes queued: next cycle `txd`=1, `busy`=0, `fifo_count`=0, `tx_ready`=1; no partial frame resumes.
- At `fifo_count`=15, push on the same edge a frame pops: `fifo_count` stays 15 and `tx_ready` stays 1.
